countdown_timer: RTL
====================

# countdown_timer

Loadable down-counter that decrements a WIDTH-bit value once per TICK_DIV clock cycles and flags expiry at zero. It is the counterpart of the lab's free-running up-count seconds timer. A top level feeds `load_value` from switches and sends `count` to the existing hex_to_seg display decoders, one nibble per HEX digit. Every output is registered; the block contains no display logic.

## Interface
Parameters:
- TICK_DIV, 50_000_000: clock cycles per decrement; legal range is 2 or more; 50 MHz gives 1 s.
- WIDTH, 16: width of `count` and `load_value`.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-high; overrides every other input.
- load  in  1  when high, captures `load_value` at the edge.
- load_value  in  WIDTH  start value, sampled only while `load` is high.
- run  in  1  level; high = count down, low = pause.
- count  out  WIDTH  current remaining value.
- tick  out  1  one-cycle pulse, high in the first cycle `count` shows a decremented value.
- done  out  1  one-cycle pulse, high in the first cycle `count` shows 0 after a decrement.
- expired  out  1  level; high while state is EXPIRED.
- state  out  2  current FSM state, for debug and LEDs.

## Operation
- States: IDLE=0, RUN=1, PAUSE=2, EXPIRED=3.
- Reset values: count=0, tick=0, done=0, expired=0, state=IDLE, prescaler=0.
- Priority at each edge: reset, then load, then FSM.
- Load, in any state: count←load_value, prescaler←0, state←IDLE, expired←0, no tick or done.
- IDLE:
  - run=1 and count≠0 → RUN.
  - run=1 and count=0 → stay in IDLE; done is not asserted.
- RUN with run=1:
  - prescaler increments.
  - At prescaler=TICK_DIV-1: prescaler←0, count←count-1, tick←1.
  - If that decrement makes count 0 (old count was 1): done←1 and state←EXPIRED.
- RUN with run=0: → PAUSE. The prescaler holds its value and no decrement happens, even if the prescaler is at its terminal value.
- PAUSE:
  - run=1 → RUN; the prescaler resumes from its held value.
  - Otherwise everything holds.
- EXPIRED:
  - count stays 0 and expired=1.
  - run is ignored.
  - Leave only by load or reset.
- Arithmetic: the prescaler is $clog2(TICK_DIV) bits. count never decrements below 0, so it never wraps from 0 to all-ones. count=all-ones loads and counts normally.

## Timing
- One cycle of FSM latency: sampling run=1 in IDLE or PAUSE gives state=RUN on the next cycle. Prescaler counting starts in the first RUN cycle.
- Decrement period is exactly TICK_DIV RUN cycles with run=1. The first decrement is visible TICK_DIV+1 cycles after run is first sampled high in IDLE.
- tick, done and the new count update on the same edge. done coincides with the final tick. expired rises on that same edge.
- load and run high in the same cycle: the load wins and state becomes IDLE. If run is still high in the next cycle, state becomes RUN one cycle after that.
- reset during RUN or PAUSE: all outputs return to their reset values at that edge.

## Structure
- Shared package countdown_pkg holds:
  - the state encoding constants (IDLE, RUN, PAUSE, EXPIRED, 2 bits);
  - the default TICK_DIV of 50_000_000 for a 50 MHz clock.
- Sub-module tick_prescaler, parameter DIV:
  - inputs: clk, reset, clear, enable;
  - output: a terminal pulse when the count reaches DIV-1 while enable is high, then wraps to 0.
- countdown_timer contains the FSM, the count register, and the tick, done and expired registers.

## Test plan
All scenarios use TICK_DIV=4 and WIDTH=16.
1. Reset for 2 cycles with all inputs high → count=0, state=IDLE, tick=done=expired=0.
2. Load 3, then run=1 held → count goes 3→2→1→0 with a 4-cycle spacing and one tick per step. done and expired rise with count=0. state=EXPIRED and holds for 20 more cycles.
3. Load 5, run=1 for 1+2 cycles, run=0 for 10 cycles, then run=1 → count stays 5 during the pause. Decrement to 4 occurs 1+2 cycles after resuming (one FSM cycle, then the 2 remaining prescaler counts).
4. While in RUN at count=2, pulse load with value 0x00A5 → next cycle count=0x00A5, state=IDLE, no tick. With run still high, decrements restart with a full 4-cycle period.
5. Load 0, then run=1 → state stays IDLE, count=0, done never asserts.
6. Load 0xFFFF and run; assert reset mid-period → count=0 and state=IDLE on that edge. In EXPIRED, toggling run causes no change; a load of 1 followed by run gives EXPIRED again after 5 cycles.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer.
// State encoding is also driven out for debug LEDs.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    // One decrement per second with a 50 MHz system clock.
    localparam int TICK_DIV_50MHZ = 50_000_000;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV counter with clear and enable.
// terminal is high in the enabled cycle where the count sits at DIV-1.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign terminal = enable && (cnt == LAST);

    // Count enabled cycles, wrapping to zero after the terminal value.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with run/pause control and expiry flag.
// All outputs come straight from registers.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_50MHZ,
    parameter int WIDTH    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             run,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             done,
    output logic             expired,
    output logic [1:0]       state
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t state_r;
    logic   presc_en;
    logic   presc_term;

    // The prescaler only advances while actually counting down.
    assign presc_en = (state_r == RUN) && run && !load;
    assign state    = state_r;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_presc (
        .clk      (clk),
        .reset    (reset),
        .clear    (load),
        .enable   (presc_en),
        .terminal (presc_term)
    );

    // Control FSM plus count, tick, done and expired registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            count   <= '0;
            tick    <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            if (load) begin
                state_r <= IDLE;
                count   <= load_value;
                expired <= 1'b0;
            end else begin
                unique case (state_r)
                    IDLE: begin
                        if (run && count != '0) begin
                            state_r <= RUN;
                        end
                    end
                    RUN: begin
                        if (!run) begin
                            state_r <= PAUSE;
                        end else if (presc_term && count != '0) begin
                            count <= count - 1'b1;
                            tick  <= 1'b1;
                            if (count == ONE) begin
                                done    <= 1'b1;
                                expired <= 1'b1;
                                state_r <= EXPIRED;
                            end
                        end
                    end
                    PAUSE: begin
                        if (run) begin
                            state_r <= RUN;
                        end
                    end
                    EXPIRED: begin
                        count   <= '0;
                        expired <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
